// File: rtl/reg_file_scoreboard.sv
// Register file with two bypassed combinational read ports, one write port,
// optional hardwired-zero r0, and a per-register pending-write scoreboard.
module reg_file_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic              RsUsed,
    input  logic              RtUsed,
    input  logic              IssueWre,
    input  logic [ADDR_W-1:0] IssueRd,
    input  logic              RegWre,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              Busy1,
    output logic              Busy2,
    output logic              Stall,
    output logic [ADDR_W:0]   PendingCount
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic ZERO_EN = (ZERO_REG != 0);
    localparam logic [ADDR_W:0] CNT_ONE = 1;
    localparam logic [DEPTH-1:0] BIT0 = 1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_next;
    logic [DEPTH-1:0]  set_mask;
    logic [DEPTH-1:0]  clr_mask;
    logic              wv;
    logic              iv;
    logic              cnt_inc;
    logic              cnt_dec;

    assign wv = RegWre & ~(ZERO_EN & (rd == '0));
    assign iv = IssueWre & ~(ZERO_EN & (IssueRd == '0));

    // Set is OR-ed in after the clear, so an issue wins over a same-index write-back.
    always_comb begin
        set_mask     = iv ? (BIT0 << IssueRd) : '0;
        clr_mask     = wv ? (BIT0 << rd) : '0;
        pending_next = (pending & ~clr_mask) | set_mask;
        cnt_inc      = iv & ~pending[IssueRd];
        cnt_dec      = wv & pending[rd] & ~(iv & (IssueRd == rd));
    end

    always_comb begin
        ReadData1 = regs[rs];
        Busy1     = pending[rs];
        if (ZERO_EN && (rs == '0)) begin
            ReadData1 = '0;
            Busy1     = 1'b0;
        end else if (wv && (rd == rs)) begin
            ReadData1 = WriteData;
            Busy1     = 1'b0;
        end
    end

    always_comb begin
        ReadData2 = regs[rt];
        Busy2     = pending[rt];
        if (ZERO_EN && (rt == '0)) begin
            ReadData2 = '0;
            Busy2     = 1'b0;
        end else if (wv && (rd == rt)) begin
            ReadData2 = WriteData;
            Busy2     = 1'b0;
        end
    end

    assign Stall = (RsUsed & Busy1) | (RtUsed & Busy2);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pending      <= '0;
            PendingCount <= '0;
        end else begin
            if (wv) begin
                regs[rd] <= WriteData;
            end
            pending <= pending_next;
            case ({cnt_inc, cnt_dec})
                2'b10:   PendingCount <= PendingCount + CNT_ONE;
                2'b01:   PendingCount <= PendingCount - CNT_ONE;
                default: PendingCount <= PendingCount;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard: one instance with hardwired r0 and one
// with r0 as an ordinary register, both driven by the same stimulus.
module tb_reg_file_scoreboard;

    logic        CLK;
    logic        RST_n;
    logic [3:0]  rs, rt, IssueRd, rd;
    logic        RsUsed, RtUsed, IssueWre, RegWre;
    logic [15:0] WriteData;

    logic [15:0] z_rd1, z_rd2, n_rd1, n_rd2;
    logic        z_busy1, z_busy2, z_stall, n_busy1, n_busy2, n_stall;
    logic [4:0]  z_cnt, n_cnt;

    int errors = 0;
    int checks = 0;

    reg_file_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) u_z (
        .CLK(CLK), .RST_n(RST_n), .rs(rs), .rt(rt), .RsUsed(RsUsed), .RtUsed(RtUsed),
        .IssueWre(IssueWre), .IssueRd(IssueRd), .RegWre(RegWre), .rd(rd),
        .WriteData(WriteData), .ReadData1(z_rd1), .ReadData2(z_rd2),
        .Busy1(z_busy1), .Busy2(z_busy2), .Stall(z_stall), .PendingCount(z_cnt)
    );

    reg_file_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0)) u_n (
        .CLK(CLK), .RST_n(RST_n), .rs(rs), .rt(rt), .RsUsed(RsUsed), .RtUsed(RtUsed),
        .IssueWre(IssueWre), .IssueRd(IssueRd), .RegWre(RegWre), .rd(rd),
        .WriteData(WriteData), .ReadData1(n_rd1), .ReadData2(n_rd2),
        .Busy1(n_busy1), .Busy2(n_busy2), .Stall(n_stall), .PendingCount(n_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        IssueWre = 1'b0;
        RegWre   = 1'b0;
    endtask

    initial begin
        RST_n = 1'b0;
        rs = '0; rt = '0; IssueRd = '0; rd = '0;
        RsUsed = 1'b0; RtUsed = 1'b0; IssueWre = 1'b0; RegWre = 1'b0;
        WriteData = '0;
        #2;
        chk("rst_rd1", z_rd1, 0);
        chk("rst_cnt", z_cnt, 0);
        chk("rst_stall", z_stall, 0);
        chk("rst_busy1", z_busy1, 0);
        #5 RST_n = 1'b1;
        tick();

        // reset mid-operation
        RegWre = 1'b1; rd = 4'd5; WriteData = 16'h1234;
        tick();
        idle(); rs = 4'd5;
        IssueWre = 1'b1; IssueRd = 4'd6;
        #1 chk("t1_rd1_before", z_rd1, 16'h1234);
        tick();
        idle();
        chk("t1_cnt_before", z_cnt, 1);
        #2 RST_n = 1'b0;
        #1;
        chk("t1_rd1_reset", z_rd1, 0);
        chk("t1_cnt_reset", z_cnt, 0);
        chk("t1_ncnt_reset", n_cnt, 0);
        #1 RST_n = 1'b1;
        tick();

        // bypass then array read; write to non-pending register
        RegWre = 1'b1; rd = 4'd3; WriteData = 16'hBEEF; rs = 4'd3; rt = 4'd3;
        #1;
        chk("t2_bypass_rd1", z_rd1, 16'hBEEF);
        chk("t2_bypass_rd2", z_rd2, 16'hBEEF);
        tick();
        idle();
        #1;
        chk("t2_array_rd1", z_rd1, 16'hBEEF);
        chk("t2_cnt", z_cnt, 0);

        // r0 handling
        RegWre = 1'b1; rd = 4'd0; WriteData = 16'hFFFF;
        IssueWre = 1'b1; IssueRd = 4'd0; rs = 4'd0;
        #1;
        chk("t3_z_bypass_r0", z_rd1, 0);
        chk("t3_n_bypass_r0", n_rd1, 16'hFFFF);
        tick();
        idle();
        #1;
        chk("t3_z_rd1", z_rd1, 0);
        chk("t3_z_busy1", z_busy1, 0);
        chk("t3_z_cnt", z_cnt, 0);
        chk("t3_n_rd1", n_rd1, 16'hFFFF);
        chk("t3_n_busy1", n_busy1, 1);
        chk("t3_n_cnt", n_cnt, 1);
        RegWre = 1'b1; rd = 4'd0; WriteData = 16'hFFFF;
        tick();
        idle();
        chk("t3_n_cnt_retired", n_cnt, 0);

        // RAW hazard on r7
        IssueWre = 1'b1; IssueRd = 4'd7;
        tick();
        idle(); rs = 4'd7; RsUsed = 1'b1;
        #1;
        chk("t4_busy1", z_busy1, 1);
        chk("t4_stall", z_stall, 1);
        chk("t4_cnt", z_cnt, 1);
        RsUsed = 1'b0;
        #1 chk("t4_stall_unused", z_stall, 0);
        RsUsed = 1'b1; RegWre = 1'b1; rd = 4'd7; WriteData = 16'h0042;
        #1;
        chk("t4_wb_busy1", z_busy1, 0);
        chk("t4_wb_stall", z_stall, 0);
        chk("t4_wb_rd1", z_rd1, 16'h0042);
        tick();
        idle(); RsUsed = 1'b0;
        chk("t4_cnt_after", z_cnt, 0);

        // simultaneous issue and write-back
        IssueWre = 1'b1; IssueRd = 4'd4;
        tick();
        chk("t5_cnt_one", z_cnt, 1);
        IssueWre = 1'b1; IssueRd = 4'd4; RegWre = 1'b1; rd = 4'd4; WriteData = 16'h0044;
        tick();
        idle(); rs = 4'd4;
        #1;
        chk("t5_same_busy1", z_busy1, 1);
        chk("t5_same_cnt", z_cnt, 1);
        IssueWre = 1'b1; IssueRd = 4'd2; RegWre = 1'b1; rd = 4'd4; WriteData = 16'h0045;
        tick();
        idle(); rs = 4'd4; rt = 4'd2;
        #1;
        chk("t5_diff_busy1", z_busy1, 0);
        chk("t5_diff_rd1", z_rd1, 16'h0045);
        chk("t5_diff_busy2", z_busy2, 1);
        chk("t5_diff_cnt", z_cnt, 1);
        RegWre = 1'b1; rd = 4'd2; WriteData = 16'h0002;
        tick();
        idle();
        chk("t5_cnt_zero", z_cnt, 0);

        // fill the scoreboard
        for (int i = 1; i < 16; i++) begin
            IssueWre = 1'b1; IssueRd = 4'(i);
            tick();
        end
        idle();
        chk("t6_z_fill", z_cnt, 15);
        chk("t6_n_fill", n_cnt, 15);
        rt = 4'd5; RtUsed = 1'b1; RsUsed = 1'b0;
        #1;
        chk("t6_busy2", z_busy2, 1);
        chk("t6_stall_rt", z_stall, 1);
        RtUsed = 1'b0;
        IssueWre = 1'b1; IssueRd = 4'd9;
        tick();
        chk("t6_reissue", z_cnt, 15);
        IssueRd = 4'd0;
        tick();
        idle();
        chk("t6_z_r0_issue", z_cnt, 15);
        chk("t6_n_full", n_cnt, 16);
        for (int i = 0; i < 8; i++) begin
            RegWre = 1'b1; rd = 4'(i); WriteData = 16'(i);
            tick();
        end
        idle();
        chk("t6_z_half", z_cnt, 8);
        chk("t6_n_half", n_cnt, 8);
        for (int i = 8; i < 16; i++) begin
            RegWre = 1'b1; rd = 4'(i); WriteData = 16'(i);
            tick();
        end
        idle();
        chk("t6_z_empty", z_cnt, 0);
        chk("t6_n_empty", n_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
